fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address loaded into PC at reset.
REQ-002 Parameter IMEM_BYTES, default 400, byte size of instruction memory; legal fetch iff pc+3 < IMEM_BYTES.
REQ-003 Parameter QDEPTH, default 2, fetch-queue entries; power of two, >=2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 inst_address  output  32  byte address driven to instruction memory; equals PC combinationally.
REQ-007 instruction  input  32  little-endian word returned by instruction memory in the same cycle as inst_address.
REQ-008 redirect_valid  input  1  branch/jump taken; flush and restart at redirect_pc.
REQ-009 redirect_pc  input  32  new fetch byte address.
REQ-010 out_valid  output  1  queue head holds a fetched entry.
REQ-011 out_ready  input  1  decode accepts head this cycle.
REQ-012 out_instr / out_pc / out_fault  output  32/32/1  head instruction word, its byte address, fault flag.

Function
REQ-013 Head is popped iff out_valid && out_ready (and no redirect); head fields stable while out_valid && !out_ready.
REQ-014 State FETCH: push {pc, instruction, fault=0} and pc <= pc+4 when queue not full, or full with pop the same cycle.
REQ-015 pc+4 wraps modulo 2^32; no saturation.
REQ-016 Fault condition: pc[1:0] != 0 or pc+3 >= IMEM_BYTES; on push in FETCH, entry has out_instr=32'h0000_0013 (NOP), out_fault=1, pc held, state -> HALT.
REQ-017 State HALT: no pushes, pc held; queued entries still drain normally.
REQ-018 redirect_valid has priority over push and pop: queue emptied, pc <= redirect_pc, no push or pop, state -> FETCH, all in one cycle.
REQ-019 Cycle after redirect: out_valid=0; first push of redirect_pc target occurs that cycle (entry visible one cycle later).
REQ-020 Fetch-to-out_valid latency: 1 cycle (push at edge N, out_valid high after edge N).
REQ-021 Queue full without pop: no push, pc held, inst_address stable.
REQ-022 Queue empty: out_valid=0; out_instr/out_pc/out_fault hold last value and are don't-care for checking.
REQ-023 Queue pointers wrap modulo QDEPTH; occupancy counter width clog2(QDEPTH)+1, never exceeds QDEPTH or underflows.

Reset
REQ-024 While reset high at an edge: pc=RESET_PC, queue empty, out_valid=0, out_instr=0, out_pc=0, out_fault=0, state=FETCH.
REQ-025 Reset overrides redirect_valid and any in-flight push/pop; no entry survives reset.
REQ-026 First push occurs in the first cycle with reset low, at pc=RESET_PC.

Structure
REQ-027 Shared package riscv_pkg holds XLEN=32, INSTR_NOP=32'h0000_0013, and fetch_state_t enum {FETCH, HALT}.
REQ-028 One sub-module fetch_queue: parameterised FIFO (width 65, depth QDEPTH) with push, pop, flush, full, empty; flush synchronous and dominant.
REQ-029 fetch_unit instantiates fetch_queue and contains the PC register and state machine only.

Verification
REQ-030 Reset release, out_ready=1, memory words 0x00500093,0x00100113 at 0,4 -> out_pc 0,4,8... one per cycle, first out_valid one cycle after reset low.
REQ-031 out_ready=0 for 5 cycles after reset -> exactly QDEPTH entries (pc 0,4), inst_address held at 8; on out_ready=1 entries drain in order with no loss or duplicate.
REQ-032 redirect_valid=1, redirect_pc=0x20 while queue full and out_ready=1 -> no pop that cycle, out_valid=0 next cycle, next out_pc=0x20.
REQ-033 Sequential fetch to pc=396 with IMEM_BYTES=400 -> entry 396 normal, entry 400 out_fault=1 out_instr=0x00000013, then no pushes until redirect_pc=0 restarts fetch.
REQ-034 redirect_pc=0x6 -> single faulted entry with out_pc=0x6, state HALT.
REQ-035 reset asserted mid-stream with queue full -> next cycle out_valid=0, inst_address=RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Definitions shared by the fetch unit and its instruction queue.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    // Layout of one queue entry: {pc, instruction, fault}
    localparam int          FQ_W      = 2 * XLEN + 1;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-queue FIFO: the head entry is visible one cycle after its push.
// Flush is synchronous and dominant.
module fetch_queue #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: the PC register and FETCH/HALT control feeding a small
// queue toward decode. Illegal fetches produce one faulted NOP and then halt.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 400,
    parameter int          QDEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] inst_address,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fault
);

    logic [31:0]     pc_q;
    logic [31:0]     pc_d;
    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic            push;
    logic            pop;
    logic            flush;
    logic            q_full;
    logic            q_empty;
    logic [FQ_W-1:0] wdata;
    logic [FQ_W-1:0] rdata;
    logic [32:0]     pc_last_byte;
    logic            fault;

    // 33-bit sum so the bounds test cannot be fooled by wrap-around near 2^32.
    assign pc_last_byte = {1'b0, pc_q} + 33'd3;
    assign fault        = (pc_q[1:0] != 2'b00) || (pc_last_byte >= 33'(IMEM_BYTES));

    assign inst_address = pc_q;
    assign out_valid    = !q_empty;
    assign pop          = out_valid && out_ready && !redirect_valid;

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        push    = 1'b0;
        flush   = 1'b0;
        wdata   = {pc_q, instruction, 1'b0};
        if (redirect_valid) begin
            flush   = 1'b1;
            pc_d    = redirect_pc;
            state_d = FETCH;
        end else if ((state_q == FETCH) && (!q_full || pop)) begin
            push = 1'b1;
            if (fault) begin
                wdata   = {pc_q, INSTR_NOP, 1'b1};
                state_d = HALT;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= FETCH;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    fetch_queue #(
        .WIDTH (FQ_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign out_pc    = rdata[FQ_W-1 -: 32];
    assign out_instr = rdata[32:1];
    assign out_fault = rdata[0];

endmodule
